// File: rtl/bf16_acc_if.sv
// Term channel from the bf16 multiplier into the accumulator, and result channel out of it.
interface bf16_acc_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FLAG_WIDTH = 4,
    parameter int unsigned CNT_WIDTH  = 8
);
    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] i_data;
    logic [FLAG_WIDTH-1:0] i_flag;
    logic                  i_last;
    logic                  o_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_data;
    logic [FLAG_WIDTH-1:0] o_flag;
    logic [CNT_WIDTH-1:0]  o_count;

    // Producer of terms / consumer of results
    modport master (
        output i_valid, i_data, i_flag, i_last, i_ready,
        input  o_ready, o_valid, o_data, o_flag, o_count
    );

    // The accumulator itself
    modport slave (
        input  i_valid, i_data, i_flag, i_last, i_ready,
        output o_ready, o_valid, o_data, o_flag, o_count
    );
endinterface

// File: rtl/bf16_acc.sv
// Sequential bf16 dot-product accumulator: one product term per 4 cycles,
// truncating arithmetic, subnormals flushed to zero, one-hot class flags.
module bf16_acc #(
    parameter int unsigned EXP_WIDTH  = 8,
    parameter int unsigned SIG_WIDTH  = 7,
    parameter int unsigned FLAG_WIDTH = 4,
    parameter int unsigned GUARD_BITS = 3,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    bf16_acc_if.slave bus
);
    localparam int unsigned WORD_W  = 1 + EXP_WIDTH + SIG_WIDTH;
    localparam int unsigned MAG_W   = SIG_WIDTH + 1 + GUARD_BITS;
    localparam int unsigned SUM_W   = MAG_W + 1;
    localparam int unsigned EXP_S_W = EXP_WIDTH + 2;
    localparam int unsigned LZ_W    = $clog2(MAG_W + 1);
    localparam int unsigned BIAS    = (1 << (EXP_WIDTH - 1)) - 1;

    localparam logic [FLAG_WIDTH-1:0] F_NAN  = FLAG_WIDTH'(4'b1000);
    localparam logic [FLAG_WIDTH-1:0] F_ZERO = FLAG_WIDTH'(4'b0100);
    localparam logic [FLAG_WIDTH-1:0] F_INF  = FLAG_WIDTH'(4'b0010);
    localparam logic [FLAG_WIDTH-1:0] F_NORM = FLAG_WIDTH'(4'b0001);

    localparam logic [WORD_W-1:0] QNAN =
        {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(SIG_WIDTH-1){1'b0}}};
    localparam logic signed [EXP_S_W-1:0] EXP_MAX   = EXP_S_W'(BIAS);
    localparam logic signed [EXP_S_W-1:0] EXP_MIN   = EXP_S_W'(1) - EXP_S_W'(BIAS);
    localparam logic [EXP_WIDTH-1:0]      SHIFT_OUT = EXP_WIDTH'(MAG_W);

    typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_OUT} state_t;

    state_t                     state_q, state_d;
    logic                       ready_q, ready_d;
    logic [WORD_W-1:0]          acc_data_q, acc_data_d;
    logic [FLAG_WIDTH-1:0]      acc_flag_q, acc_flag_d;
    logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
    logic [WORD_W-1:0]          term_data_q, term_data_d;
    logic [FLAG_WIDTH-1:0]      term_flag_q, term_flag_d;
    logic                       term_last_q, term_last_d;
    logic [MAG_W-1:0]           op_big_q, op_big_d, op_small_q, op_small_d;
    logic                       sg_big_q, sg_big_d, sg_small_q, sg_small_d;
    logic signed [EXP_S_W-1:0]  exp_q, exp_d;
    logic [SUM_W-1:0]           sum_q, sum_d;
    logic                       sum_sign_q, sum_sign_d;
    logic                       out_valid_q, out_valid_d;
    logic [WORD_W-1:0]          out_data_q, out_data_d;
    logic [FLAG_WIDTH-1:0]      out_flag_q, out_flag_d;
    logic [CNT_WIDTH-1:0]       out_cnt_q, out_cnt_d;

    logic [EXP_WIDTH-1:0]       acc_exp, term_exp, exp_diff;
    logic [MAG_W-1:0]           acc_mag, term_mag, small_raw;
    logic                       acc_big;
    logic [MAG_W-1:0]           al_big, al_small;
    logic                       al_big_sign, al_small_sign;
    logic signed [EXP_S_W-1:0]  al_exp;
    logic [SUM_W-1:0]           ad_sum;
    logic                       ad_sign;
    logic [LZ_W-1:0]            lz;
    logic                       lz_found;
    logic [MAG_W-1:0]           nm_mag;
    logic signed [EXP_S_W-1:0]  nm_exp;
    logic [SIG_WIDTH-1:0]       nm_frac;
    logic [WORD_W-1:0]          ar_data, sp_data, nx_data;
    logic [FLAG_WIDTH-1:0]      ar_flag, sp_flag, nx_flag;
    logic                       sp_bypass;

    // Align: pick the larger-exponent operand (accumulator wins ties), shift the other right
    always_comb begin
        acc_exp   = acc_data_q[WORD_W-2 -: EXP_WIDTH];
        term_exp  = term_data_q[WORD_W-2 -: EXP_WIDTH];
        acc_mag   = (acc_flag_q == F_ZERO) ? '0
                  : {1'b1, acc_data_q[SIG_WIDTH-1:0], {GUARD_BITS{1'b0}}};
        term_mag  = {1'b1, term_data_q[SIG_WIDTH-1:0], {GUARD_BITS{1'b0}}};
        acc_big   = (acc_exp >= term_exp);
        exp_diff  = acc_big ? (acc_exp - term_exp) : (term_exp - acc_exp);
        al_big    = acc_big ? acc_mag : term_mag;
        small_raw = acc_big ? term_mag : acc_mag;
        al_small  = (exp_diff >= SHIFT_OUT) ? '0 : (small_raw >> exp_diff);
        al_big_sign   = acc_big ? acc_data_q[WORD_W-1] : term_data_q[WORD_W-1];
        al_small_sign = acc_big ? term_data_q[WORD_W-1] : acc_data_q[WORD_W-1];
        al_exp    = $signed(EXP_S_W'(acc_big ? acc_exp : term_exp)) - EXP_MAX;
    end

    // Add/subtract magnitudes; a difference takes the sign of the larger magnitude
    always_comb begin
        ad_sum  = '0;
        ad_sign = sg_big_q;
        if (sg_big_q == sg_small_q) begin
            ad_sum = SUM_W'(op_big_q) + SUM_W'(op_small_q);
        end else if (op_big_q >= op_small_q) begin
            ad_sum = SUM_W'(op_big_q - op_small_q);
        end else begin
            ad_sum  = SUM_W'(op_small_q - op_big_q);
            ad_sign = sg_small_q;
        end
    end

    // Normalize (carry right-shift or leading-one left-shift), truncate, classify
    always_comb begin
        lz       = '0;
        lz_found = 1'b0;
        for (int i = MAG_W - 1; i >= 0; i--) begin
            if (!lz_found && sum_q[i]) begin
                lz       = LZ_W'(MAG_W - 1 - i);
                lz_found = 1'b1;
            end
        end
        if (sum_q[SUM_W-1]) begin
            nm_mag = sum_q[SUM_W-1:1];
            nm_exp = exp_q + EXP_S_W'(1);
        end else begin
            nm_mag = sum_q[MAG_W-1:0] << lz;
            nm_exp = exp_q - EXP_S_W'(lz);
        end
        nm_frac = SIG_WIDTH'(nm_mag >> GUARD_BITS);
        if (sum_q == '0) begin
            ar_data = '0;
            ar_flag = F_ZERO;
        end else if (nm_exp < EXP_MIN) begin
            ar_data = {sum_sign_q, {(WORD_W-1){1'b0}}};
            ar_flag = F_ZERO;
        end else if (nm_exp > EXP_MAX) begin
            ar_data = {sum_sign_q, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
            ar_flag = F_INF;
        end else begin
            ar_data = {sum_sign_q, EXP_WIDTH'(nm_exp + EXP_MAX), nm_frac};
            ar_flag = F_NORM;
        end
    end

    // Special operands bypass the arithmetic; NAN is sticky, opposite infinities give NAN
    always_comb begin
        sp_bypass = (term_flag_q != F_NORM) || (acc_flag_q == F_NAN) || (acc_flag_q == F_INF);
        sp_data   = acc_data_q;
        sp_flag   = acc_flag_q;
        if ((acc_flag_q == F_NAN) || (term_flag_q == F_NAN)) begin
            sp_data = QNAN;
            sp_flag = F_NAN;
        end else if (term_flag_q == F_INF) begin
            if ((acc_flag_q == F_INF) && (acc_data_q[WORD_W-1] != term_data_q[WORD_W-1])) begin
                sp_data = QNAN;
                sp_flag = F_NAN;
            end else begin
                sp_data = {term_data_q[WORD_W-1], {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
                sp_flag = F_INF;
            end
        end
        nx_data = sp_bypass ? sp_data : ar_data;
        nx_flag = sp_bypass ? sp_flag : ar_flag;
    end

    // Next-state and next-register values
    always_comb begin
        state_d     = state_q;
        acc_data_d  = acc_data_q;
        acc_flag_d  = acc_flag_q;
        cnt_d       = cnt_q;
        term_data_d = term_data_q;
        term_flag_d = term_flag_q;
        term_last_d = term_last_q;
        op_big_d    = op_big_q;
        op_small_d  = op_small_q;
        sg_big_d    = sg_big_q;
        sg_small_d  = sg_small_q;
        exp_d       = exp_q;
        sum_d       = sum_q;
        sum_sign_d  = sum_sign_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_flag_d  = out_flag_q;
        out_cnt_d   = out_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_valid && ready_q) begin
                    term_data_d = bus.i_data;
                    term_flag_d = bus.i_flag;
                    term_last_d = bus.i_last;
                    cnt_d       = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_WIDTH'(1);
                    state_d     = S_ALIGN;
                end
            end
            S_ALIGN: begin
                op_big_d   = al_big;
                op_small_d = al_small;
                sg_big_d   = al_big_sign;
                sg_small_d = al_small_sign;
                exp_d      = al_exp;
                state_d    = S_ADD;
            end
            S_ADD: begin
                sum_d      = ad_sum;
                sum_sign_d = ad_sign;
                state_d    = S_NORM;
            end
            S_NORM: begin
                acc_data_d = nx_data;
                acc_flag_d = nx_flag;
                if (term_last_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = nx_data;
                    out_flag_d  = nx_flag;
                    out_cnt_d   = cnt_q;
                    state_d     = S_OUT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_OUT: begin
                if (bus.i_ready) begin
                    acc_data_d  = '0;
                    acc_flag_d  = F_ZERO;
                    cnt_d       = '0;
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b1;
            acc_data_q  <= '0;
            acc_flag_q  <= F_ZERO;
            cnt_q       <= '0;
            term_data_q <= '0;
            term_flag_q <= F_ZERO;
            term_last_q <= 1'b0;
            op_big_q    <= '0;
            op_small_q  <= '0;
            sg_big_q    <= 1'b0;
            sg_small_q  <= 1'b0;
            exp_q       <= '0;
            sum_q       <= '0;
            sum_sign_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_flag_q  <= F_ZERO;
            out_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            acc_data_q  <= acc_data_d;
            acc_flag_q  <= acc_flag_d;
            cnt_q       <= cnt_d;
            term_data_q <= term_data_d;
            term_flag_q <= term_flag_d;
            term_last_q <= term_last_d;
            op_big_q    <= op_big_d;
            op_small_q  <= op_small_d;
            sg_big_q    <= sg_big_d;
            sg_small_q  <= sg_small_d;
            exp_q       <= exp_d;
            sum_q       <= sum_d;
            sum_sign_q  <= sum_sign_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_flag_q  <= out_flag_d;
            out_cnt_q   <= out_cnt_d;
        end
    end

    assign bus.o_ready = ready_q;
    assign bus.o_valid = out_valid_q;
    assign bus.o_data  = out_data_q;
    assign bus.o_flag  = out_flag_q;
    assign bus.o_count = out_cnt_q;
endmodule

// File: tb/tb_bf16_acc.sv
// Randomized self-checking bench for bf16_acc against a value-level reference model.
module tb_bf16_acc;
    localparam logic [3:0] FL_NAN  = 4'b1000;
    localparam logic [3:0] FL_ZERO = 4'b0100;
    localparam logic [3:0] FL_INF  = 4'b0010;
    localparam logic [3:0] FL_NORM = 4'b0001;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_cmp;
    int   n_err;

    logic [15:0] vec_d [0:299];
    logic [3:0]  vec_f [0:299];
    logic [15:0] m_data;
    logic [3:0]  m_flag;
    logic [7:0]  m_cnt;

    bf16_acc_if bus ();

    bf16_acc dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // Free-running clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Exact reference: value = mantissa * 2^exp, aligned with 3 guard bits, truncated
    function automatic void model_step(input logic [15:0] ad, input logic [3:0] af,
                                       input logic [15:0] td, input logic [3:0] tf,
                                       output logic [15:0] rd, output logic [3:0] rf);
        int  ea, et, e, ma, mt, s, mag;
        logic neg;
        rd = ad;
        rf = af;
        if (af == FL_NAN || tf == FL_NAN) begin
            rd = 16'h7FC0; rf = FL_NAN;
        end else if (tf == FL_INF) begin
            if (af == FL_INF && ad[15] != td[15]) begin
                rd = 16'h7FC0; rf = FL_NAN;
            end else begin
                rd = {td[15], 15'h7F80}; rf = FL_INF;
            end
        end else if (af != FL_INF && tf != FL_ZERO) begin
            mt = (128 + int'(td[6:0])) * 8;
            et = int'(td[14:7]) - 127;
            if (af == FL_ZERO) begin
                ma = 0; ea = -1000;
            end else begin
                ma = (128 + int'(ad[6:0])) * 8;
                ea = int'(ad[14:7]) - 127;
            end
            if (ea >= et) begin
                e  = ea;
                mt = (ea - et >= 11) ? 0 : (mt >> (ea - et));
            end else begin
                e  = et;
                ma = (et - ea >= 11) ? 0 : (ma >> (et - ea));
            end
            s = (ad[15] ? -ma : ma) + (td[15] ? -mt : mt);
            if (s == 0) begin
                rd = 16'h0000; rf = FL_ZERO;
            end else begin
                neg = (s < 0);
                mag = neg ? -s : s;
                while (mag >= 2048) begin mag = mag / 2; e++; end
                while (mag < 1024)  begin mag = mag * 2; e--; end
                if (e < -126) begin
                    rd = {neg, 15'h0000}; rf = FL_ZERO;
                end else if (e > 127) begin
                    rd = {neg, 15'h7F80}; rf = FL_INF;
                end else begin
                    rd = {neg, 8'(e + 127), 7'((mag / 8) % 128)}; rf = FL_NORM;
                end
            end
        end
    endfunction

    function automatic void rnd_term(output logic [15:0] d, output logic [3:0] f);
        int pick;
        logic [7:0] e;
        logic s;
        pick = $urandom_range(0, 99);
        s    = 1'($urandom_range(0, 1));
        if (pick < 6) begin
            d = {s, 15'h0000}; f = FL_ZERO;
        end else if (pick < 9) begin
            d = {s, 15'h7F80}; f = FL_INF;
        end else if (pick < 10) begin
            d = 16'h7FC0; f = FL_NAN;
        end else begin
            case ($urandom_range(0, 7))
                0:       e = 8'($urandom_range(1, 4));
                1:       e = 8'($urandom_range(250, 254));
                default: e = 8'($urandom_range(122, 132));
            endcase
            d = {s, e, 7'($urandom)};
            f = FL_NORM;
        end
    endfunction

    // Present a term and hold it until accepted; hs is the cycle of the handshake
    task automatic send_term(input logic [15:0] d, input logic [3:0] f, input logic l, output int hs);
        int w;
        w = 0;
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        bus.i_flag  = f;
        bus.i_last  = l;
        while (!bus.o_ready && w < 64) begin
            @(negedge clk);
            w++;
        end
        check("in_ready", 32'(bus.o_ready), 32'd1);
        hs = cyc;
        @(negedge clk);
        bus.i_valid = 1'b0;
    endtask

    // Wait for a result, compare it, then accept it
    task automatic get_result(input string tag, input logic [15:0] ed, input logic [3:0] ef,
                              input logic [7:0] ec, output int vc);
        int w;
        w = 0;
        while (!bus.o_valid && w < 64) begin
            @(negedge clk);
            w++;
        end
        vc = cyc;
        check({tag, "_valid"}, 32'(bus.o_valid), 32'd1);
        check({tag, "_data"},  32'(bus.o_data),  32'(ed));
        check({tag, "_flag"},  32'(bus.o_flag),  32'(ef));
        check({tag, "_count"}, 32'(bus.o_count), 32'(ec));
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_ready = 1'b0;
        check({tag, "_drop"}, 32'(bus.o_valid), 32'd0);
    endtask

    task automatic model_clear();
        m_data = 16'h0000;
        m_flag = FL_ZERO;
        m_cnt  = 8'd0;
    endtask

    // Feed vec_d/vec_f[0..n-1] as one vector; lat = cycles from first handshake to o_valid
    task automatic run_vector(input string tag, input int n, output int lat);
        int hs, first_hs, vc;
        first_hs = 0;
        for (int k = 0; k < n; k++) begin
            model_step(m_data, m_flag, vec_d[k], vec_f[k], m_data, m_flag);
            if (m_cnt != 8'hFF) m_cnt++;
            send_term(vec_d[k], vec_f[k], (k == n - 1), hs);
            if (k == 0) first_hs = hs;
        end
        get_result(tag, m_data, m_flag, m_cnt, vc);
        lat = vc - first_hs;
        model_clear();
    endtask

    task automatic set2(input logic [15:0] a, input logic [3:0] fa, input logic [15:0] b, input logic [3:0] fb);
        vec_d[0] = a; vec_f[0] = fa;
        vec_d[1] = b; vec_f[1] = fb;
    endtask

    initial begin
        int lat, n, hs;
        logic [15:0] held;
        cyc = 0; n_cmp = 0; n_err = 0;
        rst_n = 1'b0;
        bus.i_valid = 1'b0; bus.i_data = '0; bus.i_flag = FL_ZERO;
        bus.i_last = 1'b0; bus.i_ready = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(bus.o_valid), 32'd0);
        check("rst_data",  32'(bus.o_data),  32'h0000);
        check("rst_flag",  32'(bus.o_flag),  32'(FL_ZERO));
        check("rst_count", 32'(bus.o_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 32'(bus.o_ready), 32'd1);

        // 1.0 + 2.0 = 3.0, result valid 8 cycles after the first handshake cycle
        set2(16'h3F80, FL_NORM, 16'h4000, FL_NORM);
        run_vector("one_plus_two", 2, lat);
        check("latency", 32'(lat), 32'd8);
        check("one_plus_two_ref", 32'(16'h4040), 32'(bus.o_data === 16'h4040 ? 16'h4040 : bus.o_data));
        set2(16'h3F80, FL_NORM, 16'hBF80, FL_NORM);
        run_vector("cancel", 2, lat);
        set2(16'h4380, FL_NORM, 16'h3F80, FL_NORM);
        run_vector("trunc", 2, lat);
        set2(16'h3FC0, FL_NORM, 16'h3FC0, FL_NORM);
        run_vector("carry", 2, lat);
        set2(16'h3F80, FL_NORM, 16'hBF00, FL_NORM);
        run_vector("renorm", 2, lat);
        set2(16'h0100, FL_NORM, 16'h80C0, FL_NORM);
        run_vector("underflow", 2, lat);
        set2(16'h7F7F, FL_NORM, 16'h7F7F, FL_NORM);
        run_vector("overflow", 2, lat);
        set2(16'h7F80, FL_INF, 16'hFF80, FL_INF);
        run_vector("inf_cancel", 2, lat);
        set2(16'h7FC0, FL_NAN, 16'h3F80, FL_NORM);
        vec_d[2] = 16'h3F80; vec_f[2] = FL_NORM;
        run_vector("nan_sticky", 3, lat);
        set2(16'h8000, FL_ZERO, 16'h8000, FL_ZERO);
        run_vector("neg_zero", 2, lat);

        // Result held while i_ready stays low; a presented term must be ignored
        set2(16'h4040, FL_NORM, 16'h3F80, FL_NORM);
        model_step(m_data, m_flag, vec_d[0], vec_f[0], m_data, m_flag);
        model_step(m_data, m_flag, vec_d[1], vec_f[1], m_data, m_flag);
        held = m_data;
        send_term(vec_d[0], vec_f[0], 1'b0, hs);
        send_term(vec_d[1], vec_f[1], 1'b1, hs);
        n = 0;
        while (!bus.o_valid && n < 64) begin @(negedge clk); n++; end
        bus.i_valid = 1'b1; bus.i_data = 16'h4500; bus.i_flag = FL_NORM; bus.i_last = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.o_valid), 32'd1);
            check("hold_data",  32'(bus.o_data),  32'(held));
            check("hold_ready", 32'(bus.o_ready), 32'd0);
        end
        bus.i_valid = 1'b0;
        get_result("hold", held, FL_NORM, 8'd2, lat);
        model_clear();
        vec_d[0] = 16'h3F80; vec_f[0] = FL_NORM;
        run_vector("after_hold", 1, lat);

        // Reset while the first term is being aligned
        send_term(16'h4000, FL_NORM, 1'b0, hs);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.o_valid), 32'd0);
        check("midrst_data",  32'(bus.o_data),  32'h0000);
        check("midrst_flag",  32'(bus.o_flag),  32'(FL_ZERO));
        check("midrst_count", 32'(bus.o_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        @(negedge clk);
        vec_d[0] = 16'h4040; vec_f[0] = FL_NORM;
        run_vector("after_rst", 1, lat);

        // Random vectors
        for (int v = 0; v < 40; v++) begin
            n = $urandom_range(1, 6);
            for (int k = 0; k < n; k++) rnd_term(vec_d[k], vec_f[k]);
            run_vector($sformatf("rnd%0d", v), n, lat);
        end

        // Count saturation
        for (int k = 0; k < 260; k++) rnd_term(vec_d[k], vec_f[k]);
        run_vector("saturate", 260, lat);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
